alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared `alu`. It grants one operation at a time with round-robin fairness and registers the operands into the ALU. It waits out the ALU's configured latency and returns the tagged result through a backpressured response port. It sits between the execute-stage issue logic (requester 0) and the address/branch-compare helper (requester 1), so both can use one ALU instance.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `SEL_WIDTH`, default 4: ALU operation select width.
- `ALU_LATENCY`, default 0: ALU output latency; 0 or 1, passed to `alu.REG_OUTPUT`. Any other value is an elaboration error.

- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-high (asserted when 1).
- `i_req0_valid`  in  1  requester 0 has an operation.
- `o_req0_ready`  out  1  requester 0 granted this cycle.
- `i_req0_a`, `i_req0_b`  in  DATA_WIDTH  requester 0 operands.
- `i_req0_sel`  in  SEL_WIDTH  requester 0 op.
- `i_req1_valid`, `o_req1_ready`, `i_req1_a`, `i_req1_b`, `i_req1_sel`: same as the requester 0 ports, for requester 1.
- `o_rsp_valid`  out  1  result available.
- `i_rsp_ready`  in  1  consumer accepts result.
- `o_rsp_id`  out  1  requester that issued the result.
- `o_rsp_data`  out  DATA_WIDTH  ALU result.
- `o_rsp_zero`  out  1  ALU zero flag for the result.
- `o_busy`  out  1  state is not IDLE.

## Operation
- FSM states:
  - IDLE → EXEC when any request is valid.
  - EXEC → RESP after ALU_LATENCY+1 cycles.
  - RESP → IDLE on response handshake with no valid request.
  - RESP → EXEC on response handshake with a valid request (back-to-back issue).
- Grant window: IDLE, or RESP with `i_rsp_ready`=1. No grant in any other state.
- Ready outputs are combinational from state, valids, `i_rsp_ready` and the priority pointer. At most one ready is high. A ready never rises without the matching valid.
- Round-robin:
  - A 1-bit pointer holds the last granted id.
  - If both requesters are valid, the requester other than the pointer wins. A lone valid requester always wins.
  - The pointer updates to the winner on each grant.
  - Reset value of the pointer is 1, so requester 0 wins the first contention.
- On grant, the winner's a/b/sel and id are latched into operand registers that drive the ALU. The requester may change its inputs after the handshake.
- An EXEC cycle counter counts 0..ALU_LATENCY. On the last EXEC cycle, ALU `o_data`/`o_zero` and the id are captured into the response registers.
- In RESP, `o_rsp_*` are held stable until `i_rsp_ready`. This is valid/ready semantics: valid never drops without a handshake.
- `sel` values are not checked. Undefined encodings pass through and get the ALU default (add).
- Arithmetic is entirely inside `alu`, mod 2^DATA_WIDTH. The block adds no width changes.

## Timing
- All outputs reset to 0: `o_rsp_valid`, `o_rsp_id`, `o_rsp_data`, `o_rsp_zero`, `o_busy`, and both readys. State resets to IDLE, counter to 0, pointer to 1.
- Reset mid-operation aborts the in-flight op with no response produced. The next grant after release follows reset priority.
- Request handshake in cycle C0 puts the block in EXEC during C1..C1+ALU_LATENCY. `o_rsp_valid` rises in C2+ALU_LATENCY: 2 cycles at latency 0, 3 at latency 1.
- A response handshake and a new grant may occur in the same cycle. Sustained throughput is one op per ALU_LATENCY+2 cycles with `i_rsp_ready` held at 1.
- Backpressure: while RESP holds with `i_rsp_ready`=0, both readys stay 0 and requests stall without loss.
- Simultaneous valids in the grant window resolve by the pointer only. Valid arrival order is not tracked.

## Structure
- Shared package `riscv_pkg`:
  - `alu_op_e` with ADD=0000, SUB=0001, SLL=0010, SLT=0011 (signed), SLTU=0100, XOR=0101, SRL=0110, SRA=0111, OR=1000, AND=1001.
  - `ALU_SEL_WIDTH`=4.
  - The state enum stays local to the block.
- One sub-module: `alu`, instantiated with REG_OUTPUT=ALU_LATENCY and clocked by `clk`.

## Test plan
- Single op, latency 0. Req0 SUB a=5 b=5. Handshake C0 → `o_rsp_valid` in C2, data=0, zero=1, id=0.
- Contention from reset, both valid and held. Req0 ADD 7+8; req1 AND 0xF0F0_0000 & 0xFF00_FF00. Grants alternate 0,1,0 with responses 15 (id 0), 0xF000_0000 (id 1), 15 (id 0).
- Backpressure. `i_rsp_ready`=0 for 5 cycles in RESP → response fields stable and both readys 0. On release, the response handshake and the next grant happen in the same cycle.
- Latency 1. SRA 0x8000_0000 by 1 → 0xC000_0000, `o_rsp_valid` 3 cycles after handshake. Then SLL 1 by 31 → 0x8000_0000.
- Corner ops:
  - ADD 0xFFFF_FFFF+1 → 0, zero=1.
  - SLTU 0xFFFF_FFFE,1 → 0.
  - SLT 0xFFFF_FFFB(-5),3 → 1.
- Reset asserted during EXEC → all outputs 0 the same cycle. After release, no stale response appears, and on contention req0 is granted first.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: ALU operation encodings and select width.
package riscv_pkg;

  localparam int ALU_SEL_WIDTH = 4;

  typedef enum logic [ALU_SEL_WIDTH-1:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    SLL  = 4'b0010,
    SLT  = 4'b0011,
    SLTU = 4'b0100,
    XOR  = 4'b0101,
    SRL  = 4'b0110,
    SRA  = 4'b0111,
    OR   = 4'b1000,
    AND  = 4'b1001
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Integer ALU with an optional output register stage (REG_OUTPUT = 0 or 1).
module alu
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = ALU_SEL_WIDTH,
  parameter int REG_OUTPUT = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_zero
);

  localparam int SHW = $clog2(DATA_WIDTH);

  if (SEL_WIDTH < ALU_SEL_WIDTH) begin : gBadSel
    $error("alu: SEL_WIDTH must be at least ALU_SEL_WIDTH");
  end

  logic [SHW-1:0]           shamt;
  logic [ALU_SEL_WIDTH-1:0] opCode;
  logic                     upperClear;
  logic [DATA_WIDTH-1:0]    result;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     zero_q;

  assign shamt      = i_b[SHW-1:0];
  assign opCode     = i_sel[ALU_SEL_WIDTH-1:0];
  assign upperClear = ((i_sel >> ALU_SEL_WIDTH) == '0);

  // Unknown encodings (including any set upper select bits) fall back to add.
  always_comb begin
    result = i_a + i_b;
    if (upperClear) begin
      case (alu_op_e'(opCode))
        SUB:     result = i_a - i_b;
        SLL:     result = i_a << shamt;
        SLT:     result = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
        SLTU:    result = {{(DATA_WIDTH-1){1'b0}}, (i_a < i_b)};
        XOR:     result = i_a ^ i_b;
        SRL:     result = i_a >> shamt;
        SRA:     result = $unsigned($signed(i_a) >>> shamt);
        OR:      result = i_a | i_b;
        AND:     result = i_a & i_b;
        default: result = i_a + i_b;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      data_q <= '0;
      zero_q <= 1'b0;
    end else begin
      data_q <= result;
      zero_q <= (result == '0);
    end
  end

  assign o_data = (REG_OUTPUT != 0) ? data_q : result;
  assign o_zero = (REG_OUTPUT != 0) ? zero_q : (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters,
// returning tagged results through a valid/ready response port.
module alu_arbiter
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = ALU_SEL_WIDTH,
  parameter int ALU_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [DATA_WIDTH-1:0] i_req0_a,
  input  logic [DATA_WIDTH-1:0] i_req0_b,
  input  logic [SEL_WIDTH-1:0]  i_req0_sel,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [DATA_WIDTH-1:0] i_req1_a,
  input  logic [DATA_WIDTH-1:0] i_req1_b,
  input  logic [SEL_WIDTH-1:0]  i_req1_sel,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_id,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_zero,
  output logic                  o_busy
);

  if (ALU_LATENCY != 0 && ALU_LATENCY != 1) begin : gBadLatency
    $error("alu_arbiter: ALU_LATENCY must be 0 or 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic LAST_CNT = (ALU_LATENCY == 1);

  state_e                state_q;
  logic                  cnt_q;
  logic                  ptr_q;
  logic                  ptr_d;
  logic [DATA_WIDTH-1:0] opA_q;
  logic [DATA_WIDTH-1:0] opB_q;
  logic [SEL_WIDTH-1:0]  opSel_q;
  logic                  opId_q;
  logic                  rspValid_q;
  logic                  rspId_q;
  logic [DATA_WIDTH-1:0] rspData_q;
  logic                  rspZero_q;

  logic                  aluZero;
  logic [DATA_WIDTH-1:0] aluData;
  logic                  grantWindow;
  logic                  anyValid;
  logic                  winner;
  logic                  grant;
  logic                  lastExec;

  // Readys are gated by reset so they drop asynchronously along with the state.
  assign grantWindow = !reset_n &&
                       ((state_q == IDLE) || ((state_q == RESP) && i_rsp_ready));
  assign anyValid    = i_req0_valid || i_req1_valid;
  assign winner      = (i_req0_valid && i_req1_valid) ? ~ptr_q : i_req1_valid;
  assign grant       = grantWindow && anyValid;
  assign ptr_d       = grant ? winner : ptr_q;
  assign lastExec    = (state_q == EXEC) && (cnt_q == LAST_CNT);

  assign o_req0_ready = grant && !winner;
  assign o_req1_ready = grant && winner;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 1'b0;
      ptr_q      <= 1'b1;
      opA_q      <= '0;
      opB_q      <= '0;
      opSel_q    <= '0;
      opId_q     <= 1'b0;
      rspValid_q <= 1'b0;
      rspId_q    <= 1'b0;
      rspData_q  <= '0;
      rspZero_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (grant) begin
        opA_q   <= winner ? i_req1_a   : i_req0_a;
        opB_q   <= winner ? i_req1_b   : i_req0_b;
        opSel_q <= winner ? i_req1_sel : i_req0_sel;
        opId_q  <= winner;
      end
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q <= EXEC;
            cnt_q   <= 1'b0;
          end
        end
        EXEC: begin
          if (lastExec) begin
            rspValid_q <= 1'b1;
            rspId_q    <= opId_q;
            rspData_q  <= aluData;
            rspZero_q  <= aluZero;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            rspValid_q <= 1'b0;
            if (grant) begin
              state_q <= EXEC;
              cnt_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH),
    .REG_OUTPUT (ALU_LATENCY)
  ) uAlu (
    .clk     (clk),
    .reset_n (reset_n),
    .i_a     (opA_q),
    .i_b     (opB_q),
    .i_sel   (opSel_q),
    .o_data  (aluData),
    .o_zero  (aluZero)
  );

  assign o_rsp_valid = rspValid_q;
  assign o_rsp_id    = rspId_q;
  assign o_rsp_data  = rspData_q;
  assign o_rsp_zero  = rspZero_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one instance at ALU latency 0, one at latency 1.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;

  logic        req0Valid [2];
  logic        req1Valid [2];
  logic        req0Rdy   [2];
  logic        req1Rdy   [2];
  logic [31:0] req0A     [2];
  logic [31:0] req0B     [2];
  logic [31:0] req1A     [2];
  logic [31:0] req1B     [2];
  logic [3:0]  req0Sel   [2];
  logic [3:0]  req1Sel   [2];
  logic        rspValid  [2];
  logic        rspRdyIn  [2];
  logic        rspId     [2];
  logic [31:0] rspData   [2];
  logic        rspZero   [2];
  logic        busy      [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    alu_arbiter #(
      .DATA_WIDTH  (32),
      .SEL_WIDTH   (4),
      .ALU_LATENCY (g)
    ) uDut (
      .clk          (clk),
      .reset_n      (reset),
      .i_req0_valid (req0Valid[g]),
      .o_req0_ready (req0Rdy[g]),
      .i_req0_a     (req0A[g]),
      .i_req0_b     (req0B[g]),
      .i_req0_sel   (req0Sel[g]),
      .i_req1_valid (req1Valid[g]),
      .o_req1_ready (req1Rdy[g]),
      .i_req1_a     (req1A[g]),
      .i_req1_b     (req1B[g]),
      .i_req1_sel   (req1Sel[g]),
      .o_rsp_valid  (rspValid[g]),
      .i_rsp_ready  (rspRdyIn[g]),
      .o_rsp_id     (rspId[g]),
      .o_rsp_data   (rspData[g]),
      .o_rsp_zero   (rspZero[g]),
      .o_busy       (busy[g])
    );
  end

  typedef struct {
    bit          id;
    logic [31:0] data;
    bit          zero;
  } rsp_t;

  // Requester-side stimulus state: a pending request is held until granted.
  bit          pend    [2][2];
  logic [31:0] opA     [2][2];
  logic [31:0] opB     [2][2];
  logic [3:0]  opSel   [2][2];
  bit          rspRdyS [2];

  // Transaction-level reference model.
  bit   mBusy [2];
  bit   mRsp  [2];
  int   mCnt  [2];
  bit   mPtr  [2];
  bit   gV    [2];
  bit   gId   [2];
  bit   obsG  [2];
  bit   obsId [2];
  rsp_t expQ  [2][$];

  int checks = 0;
  int passes = 0;

  bit          prevHold  [2];
  bit          prevId    [2];
  logic [31:0] prevData  [2];
  bit          prevZero  [2];
  rsp_t        monExp;

  function automatic logic [31:0] aluRef(logic [3:0] sel, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    sh = b % 32;
    case (sel)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << sh;
      4'd3:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    r = (a < b) ? 32'd1 : 32'd0;
      4'd5:    r = a ^ b;
      4'd6:    r = a >> sh;
      4'd7:    r = 32'($signed(a) >>> sh);
      4'd8:    r = a | b;
      4'd9:    r = a & b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic failNow(string name);
    checks++;
    $display("[TB] FAIL %s: got timeout expected completion", name);
  endtask

  task automatic initModels();
    for (int d = 0; d < 2; d++) begin
      mBusy[d] = 0; mRsp[d] = 0; mCnt[d] = 0; mPtr[d] = 1; gV[d] = 0;
      expQ[d].delete();
    end
  endtask

  task automatic checkResetOutputs(int d);
    checkOutput($sformatf("d%0d reset rsp_valid", d), 32'(rspValid[d]), 0);
    checkOutput($sformatf("d%0d reset rsp_id", d), 32'(rspId[d]), 0);
    checkOutput($sformatf("d%0d reset rsp_data", d), rspData[d], 0);
    checkOutput($sformatf("d%0d reset rsp_zero", d), 32'(rspZero[d]), 0);
    checkOutput($sformatf("d%0d reset busy", d), 32'(busy[d]), 0);
    checkOutput($sformatf("d%0d reset ready0", d), 32'(req0Rdy[d]), 0);
    checkOutput($sformatf("d%0d reset ready1", d), 32'(req1Rdy[d]), 0);
  endtask

  // One clock cycle: drive, predict grants, compare control outputs, advance model.
  task automatic applyStimulus();
    bit window, win, v0, v1;
    logic [31:0] res;
    for (int d = 0; d < 2; d++) begin
      req0Valid[d] = pend[d][0]; req0A[d] = opA[d][0]; req0B[d] = opB[d][0]; req0Sel[d] = opSel[d][0];
      req1Valid[d] = pend[d][1]; req1A[d] = opA[d][1]; req1B[d] = opB[d][1]; req1Sel[d] = opSel[d][1];
      rspRdyIn[d] = rspRdyS[d];
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      v0 = pend[d][0];
      v1 = pend[d][1];
      window = !mBusy[d] || (mRsp[d] && rspRdyS[d]);
      win = (v0 && v1) ? !mPtr[d] : v1;
      gV[d] = window && (v0 || v1);
      gId[d] = win;
      obsG[d] = req0Rdy[d] || req1Rdy[d];
      obsId[d] = req1Rdy[d];
      checkOutput($sformatf("d%0d ready0", d), 32'(req0Rdy[d]), 32'(gV[d] && !win));
      checkOutput($sformatf("d%0d ready1", d), 32'(req1Rdy[d]), 32'(gV[d] && win));
      checkOutput($sformatf("d%0d rsp_valid", d), 32'(rspValid[d]), 32'(mRsp[d]));
      checkOutput($sformatf("d%0d busy", d), 32'(busy[d]), 32'(mBusy[d]));
      if (gV[d]) begin
        res = aluRef(opSel[d][win], opA[d][win], opB[d][win]);
        expQ[d].push_back('{id: win, data: res, zero: (res == 0)});
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (mRsp[d] && rspRdyS[d]) begin
        mRsp[d] = 0;
        mBusy[d] = 0;
      end
      if (mCnt[d] > 0) begin
        mCnt[d]--;
        if (mCnt[d] == 0) mRsp[d] = 1;
      end
      if (gV[d]) begin
        mBusy[d] = 1;
        mCnt[d] = d + 1;
        mPtr[d] = gId[d];
        pend[d][gId[d]] = 0;
      end
    end
    #2;
  endtask

  task automatic issueOp(int d, int r, logic [31:0] a, logic [31:0] b, logic [3:0] sel);
    pend[d][r] = 1; opA[d][r] = a; opB[d][r] = b; opSel[d][r] = sel;
    for (int i = 0; i < 40 && pend[d][r]; i++) applyStimulus();
    if (pend[d][r]) failNow($sformatf("d%0d grant wait", d));
  endtask

  task automatic drain(int d);
    bit done;
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      done = !pend[d][0] && !pend[d][1] && !mBusy[d] && (expQ[d].size() == 0);
      if (!done) applyStimulus();
    end
    if (!done) failNow($sformatf("d%0d drain", d));
  endtask

  // Monitor: pops the scoreboard on every response handshake, checks hold stability.
  always @(negedge clk) begin
    if (reset) begin
      prevHold = '{0, 0};
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (prevHold[d]) begin
          checkOutput($sformatf("d%0d hold valid", d), 32'(rspValid[d]), 1);
          checkOutput($sformatf("d%0d hold id", d), 32'(rspId[d]), 32'(prevId[d]));
          checkOutput($sformatf("d%0d hold data", d), rspData[d], prevData[d]);
          checkOutput($sformatf("d%0d hold zero", d), 32'(rspZero[d]), 32'(prevZero[d]));
        end
        if (rspValid[d] && rspRdyIn[d]) begin
          if (expQ[d].size() == 0) begin
            checks++;
            $display("[TB] FAIL d%0d unexpected response: got data %h expected none", d, rspData[d]);
          end else begin
            monExp = expQ[d].pop_front();
            checkOutput($sformatf("d%0d rsp id", d), 32'(rspId[d]), 32'(monExp.id));
            checkOutput($sformatf("d%0d rsp data", d), rspData[d], monExp.data);
            checkOutput($sformatf("d%0d rsp zero", d), 32'(rspZero[d]), 32'(monExp.zero));
          end
        end
        prevHold[d] = rspValid[d] && !rspRdyIn[d];
        prevId[d]   = rspId[d];
        prevData[d] = rspData[d];
        prevZero[d] = rspZero[d];
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order[$];
    int expOrder[3];
    int grants;
    expOrder = '{0, 1, 0};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rspRdyS[d] = 1;
      for (int r = 0; r < 2; r++) begin
        pend[d][r] = 0; opA[d][r] = 0; opB[d][r] = 0; opSel[d][r] = 0;
      end
      req0Valid[d] = 1; req1Valid[d] = 1; rspRdyIn[d] = 1;
      req0A[d] = 0; req0B[d] = 0; req0Sel[d] = 0;
      req1A[d] = 0; req1B[d] = 0; req1Sel[d] = 0;
    end
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) checkResetOutputs(d);
    for (int d = 0; d < 2; d++) begin req0Valid[d] = 0; req1Valid[d] = 0; end
    reset = 1'b0;
    initModels();

    // Contention from reset: grants must alternate 0,1,0.
    pend[0][0] = 1; opA[0][0] = 7; opB[0][0] = 8; opSel[0][0] = 4'd0;
    pend[0][1] = 1; opA[0][1] = 32'hF0F0_0000; opB[0][1] = 32'hFF00_FF00; opSel[0][1] = 4'd9;
    grants = 0;
    for (int i = 0; i < 40 && grants < 3; i++) begin
      applyStimulus();
      if (obsG[0]) order.push_back(int'(obsId[0]));
      if (gV[0]) begin
        grants++;
        if (grants < 3) pend[0][gId[0]] = 1;
        else begin pend[0][0] = 0; pend[0][1] = 0; end
      end
    end
    if (order.size() < 3) failNow("contention grant order");
    else for (int i = 0; i < 3; i++) checkOutput($sformatf("grant order %0d", i), 32'(order[i]), 32'(expOrder[i]));
    drain(0);

    // Single op at latency 0, then corner ops.
    issueOp(0, 0, 5, 5, 4'd1);
    drain(0);
    issueOp(0, 1, 32'hFFFF_FFFF, 1, 4'd0);
    drain(0);
    issueOp(0, 0, 32'hFFFF_FFFE, 1, 4'd4);
    drain(0);
    issueOp(0, 1, 32'hFFFF_FFFB, 3, 4'd3);
    drain(0);

    // Backpressure: response held with rsp_ready low while another request waits.
    rspRdyS[0] = 0;
    issueOp(0, 0, 32'h1234_5678, 32'h0000_0001, 4'd5);
    pend[0][1] = 1; opA[0][1] = 32'h00FF_0000; opB[0][1] = 32'h0F0F_0F0F; opSel[0][1] = 4'd8;
    repeat (7) applyStimulus();
    rspRdyS[0] = 1;
    applyStimulus();
    checkOutput("bp same-cycle grant", 32'(obsG[0] && obsId[0]), 1);
    drain(0);

    // Latency 1 instance.
    issueOp(1, 0, 32'h8000_0000, 1, 4'd7);
    drain(1);
    issueOp(1, 1, 1, 31, 4'd2);
    drain(1);

    // Randomized traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        rspRdyS[d] = ($urandom_range(0, 99) < 70);
        for (int r = 0; r < 2; r++) begin
          if (!pend[d][r] && $urandom_range(0, 99) < 40) begin
            pend[d][r] = 1;
            opA[d][r] = $urandom;
            opB[d][r] = ($urandom_range(0, 3) == 0) ? opA[d][r] : $urandom;
            opSel[d][r] = 4'($urandom_range(0, 15));
          end
        end
      end
      applyStimulus();
    end
    rspRdyS[0] = 1; rspRdyS[1] = 1;
    drain(0);
    drain(1);

    // Reset during EXEC: outputs clear at once, no stale response, req0 wins first.
    pend[0][0] = 1; opA[0][0] = 1; opB[0][0] = 2; opSel[0][0] = 4'd0;
    pend[0][1] = 1; opA[0][1] = 3; opB[0][1] = 4; opSel[0][1] = 4'd0;
    applyStimulus();
    applyStimulus();
    checkOutput("pre-reset busy", 32'(busy[0]), 1);
    pend[0][0] = 1;
    req0Valid[0] = 1; req1Valid[0] = 1; req0Valid[1] = 1; req1Valid[1] = 1;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) checkResetOutputs(d);
    req0Valid[1] = 0; req1Valid[1] = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    initModels();
    applyStimulus();
    checkOutput("post-reset first grant req0", 32'(obsG[0] && !obsId[0]), 1);
    drain(0);
    drain(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
